// File: rtl/mem_xfer_pkg.sv
// Shared types for the SRAM load/compute/store sequencer: state encoding,
// default widths and the per-memory control bundle.
package mem_xfer_pkg;

    localparam int ADDR_W_DEF = 13;
    localparam int LEN_W_DEF  = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_W = 3'd1,
        ST_LOAD_A = 3'd2,
        ST_CALC   = 3'd3,
        ST_STORE  = 3'd4,
        ST_FIN    = 3'd5
    } state_t;

    // cen/wen are active-low, ren is active-high
    typedef struct packed {
        logic cen;
        logic wen;
        logic ren;
    } mem_ctl_t;

    localparam mem_ctl_t MEM_IDLE = '{cen: 1'b1, wen: 1'b1, ren: 1'b0};
    localparam mem_ctl_t MEM_RD   = '{cen: 1'b0, wen: 1'b1, ren: 1'b1};
    localparam mem_ctl_t MEM_WR   = '{cen: 1'b0, wen: 1'b0, ren: 1'b0};

endpackage

// File: rtl/xfer_agen.sv
// Phase cycle counter shared by LOAD_W/LOAD_A/CALC/STORE. nxt_idx is the read
// index of the coming cycle; cur_idx is the same index one cycle later (write side).
module xfer_agen
    import mem_xfer_pkg::*;
#(
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             EN,
    input  logic             restart,
    output logic [LEN_W-1:0] nxt_idx,
    output logic [LEN_W-1:0] cur_idx
);

    logic [LEN_W-1:0] cnt;

    assign nxt_idx = restart ? '0 : cnt + 1'b1;
    assign cur_idx = cnt;

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt <= '0;
        end else if (EN) begin
            cnt <= nxt_idx;
        end
    end

endmodule

// File: rtl/mem_xfer_sequencer.sv
// Load weights/activations from shared SRAM, hold a CALC window, store results.
// Every output is a flop loaded from the decode of the next state and phase index.
module mem_xfer_sequencer
    import mem_xfer_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              EN,
    input  logic              START,
    input  logic              REUSE_W,
    input  logic [ADDR_W-1:0] WADDR,
    input  logic [ADDR_W-1:0] IADDR,
    input  logic [ADDR_W-1:0] OADDR,
    input  logic [LEN_W-1:0]  W_LEN,
    input  logic [LEN_W-1:0]  I_LEN,
    input  logic [LEN_W-1:0]  O_LEN,
    input  logic [LEN_W-1:0]  CALC_LEN,
    output logic [2:0]        STATE,
    output logic              BUSY,
    output logic              DONE,
    output logic              W_EN,
    output logic              SELECTOR,
    output logic              share_cen,
    output logic              share_wen,
    output logic              share_ren,
    output logic [ADDR_W-1:0] share_addr,
    output logic              weight_cen,
    output logic              weight_wen,
    output logic              weight_ren,
    output logic [ADDR_W-1:0] weight_addr,
    output logic              activate_cen,
    output logic              activate_wen,
    output logic              activate_ren,
    output logic [ADDR_W-1:0] activate_addr,
    output logic              output_cen,
    output logic              output_wen,
    output logic              output_ren,
    output logic [ADDR_W-1:0] output_addr
);

    state_t            state, state_nxt;
    logic              from_idle, accept, phase_restart;
    logic [LEN_W-1:0]  nxt_idx, cur_idx, c_last;

    logic [ADDR_W-1:0] w_base_q, i_base_q, o_base_q;
    logic [ADDR_W-1:0] w_base_n, i_base_n, o_base_n;
    logic [LEN_W-1:0]  w_len_q, i_len_q, o_len_q, c_len_q;
    logic [LEN_W-1:0]  w_len_n, i_len_n, o_len_n, c_len_n;

    mem_ctl_t          share_q, weight_q, act_q, out_q;
    mem_ctl_t          share_n, weight_n, act_n, out_n;
    logic [ADDR_W-1:0] share_addr_q, weight_addr_q, act_addr_q, out_addr_q;
    logic [ADDR_W-1:0] share_addr_n, weight_addr_n, act_addr_n, out_addr_n;
    logic              busy_q, done_q, w_en_q, sel_q;
    logic              busy_n, done_n, w_en_n, sel_n;

    // In IDLE the live inputs are what gets latched on the accepting edge.
    assign from_idle = (state == ST_IDLE);
    assign accept    = from_idle && START;
    assign w_base_n  = from_idle ? WADDR    : w_base_q;
    assign i_base_n  = from_idle ? IADDR    : i_base_q;
    assign o_base_n  = from_idle ? OADDR    : o_base_q;
    assign w_len_n   = from_idle ? W_LEN    : w_len_q;
    assign i_len_n   = from_idle ? I_LEN    : i_len_q;
    assign o_len_n   = from_idle ? O_LEN    : o_len_q;
    assign c_len_n   = from_idle ? CALC_LEN : c_len_q;
    assign c_last    = (c_len_n == '0) ? '0 : c_len_n - 1'b1;

    assign phase_restart = (state_nxt != state);

    xfer_agen #(.LEN_W(LEN_W)) u_agen (
        .CLK     (CLK),
        .RESET   (RESET),
        .EN      (EN),
        .restart (phase_restart),
        .nxt_idx (nxt_idx),
        .cur_idx (cur_idx)
    );

    // NOTE: every always_comb output gets a default before the case so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (START) begin
                    if (!REUSE_W && W_LEN != '0) state_nxt = ST_LOAD_W;
                    else if (I_LEN != '0)        state_nxt = ST_LOAD_A;
                    else                         state_nxt = ST_CALC;
                end
            end
            ST_LOAD_W: if (cur_idx == w_len_n) state_nxt = (i_len_n != '0) ? ST_LOAD_A : ST_CALC;
            ST_LOAD_A: if (cur_idx == i_len_n) state_nxt = ST_CALC;
            ST_CALC:   if (cur_idx == c_last)  state_nxt = (o_len_n != '0) ? ST_STORE : ST_FIN;
            ST_STORE:  if (cur_idx == o_len_n) state_nxt = ST_FIN;
            ST_FIN:    state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Reads issue at nxt_idx; the matching write lands one cycle later at cur_idx.
    always_comb begin
        share_n       = MEM_IDLE;
        weight_n      = MEM_IDLE;
        act_n         = MEM_IDLE;
        out_n         = MEM_IDLE;
        share_addr_n  = share_addr_q;
        weight_addr_n = weight_addr_q;
        act_addr_n    = act_addr_q;
        out_addr_n    = out_addr_q;
        busy_n        = (state_nxt != ST_IDLE);
        done_n        = (state_nxt == ST_FIN);
        w_en_n        = 1'b0;
        sel_n         = 1'b0;
        unique case (state_nxt)
            ST_LOAD_W: begin
                if (nxt_idx < w_len_n) begin
                    share_n      = MEM_RD;
                    share_addr_n = w_base_n + ADDR_W'(nxt_idx);
                end
                if (nxt_idx != '0) begin
                    weight_n      = MEM_WR;
                    weight_addr_n = ADDR_W'(cur_idx);
                end
            end
            ST_LOAD_A: begin
                sel_n = 1'b1;
                if (nxt_idx < i_len_n) begin
                    share_n      = MEM_RD;
                    share_addr_n = i_base_n + ADDR_W'(nxt_idx);
                end
                if (nxt_idx != '0) begin
                    act_n      = MEM_WR;
                    act_addr_n = ADDR_W'(cur_idx);
                end
            end
            ST_CALC: w_en_n = (nxt_idx == '0);
            ST_STORE: begin
                if (nxt_idx < o_len_n) begin
                    out_n      = MEM_RD;
                    out_addr_n = ADDR_W'(nxt_idx);
                end
                if (nxt_idx != '0) begin
                    share_n      = MEM_WR;
                    share_addr_n = o_base_n + ADDR_W'(cur_idx);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state         <= ST_IDLE;
            w_base_q      <= '0;
            i_base_q      <= '0;
            o_base_q      <= '0;
            w_len_q       <= '0;
            i_len_q       <= '0;
            o_len_q       <= '0;
            c_len_q       <= '0;
            share_q       <= MEM_IDLE;
            weight_q      <= MEM_IDLE;
            act_q         <= MEM_IDLE;
            out_q         <= MEM_IDLE;
            share_addr_q  <= '0;
            weight_addr_q <= '0;
            act_addr_q    <= '0;
            out_addr_q    <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            w_en_q        <= 1'b0;
            sel_q         <= 1'b0;
        end else if (EN) begin
            state         <= state_nxt;
            share_q       <= share_n;
            weight_q      <= weight_n;
            act_q         <= act_n;
            out_q         <= out_n;
            share_addr_q  <= share_addr_n;
            weight_addr_q <= weight_addr_n;
            act_addr_q    <= act_addr_n;
            out_addr_q    <= out_addr_n;
            busy_q        <= busy_n;
            done_q        <= done_n;
            w_en_q        <= w_en_n;
            sel_q         <= sel_n;
            if (accept) begin
                w_base_q <= WADDR;
                i_base_q <= IADDR;
                o_base_q <= OADDR;
                w_len_q  <= W_LEN;
                i_len_q  <= I_LEN;
                o_len_q  <= O_LEN;
                c_len_q  <= CALC_LEN;
            end
        end
    end

    assign STATE         = state;
    assign BUSY          = busy_q;
    assign DONE          = done_q;
    assign W_EN          = w_en_q;
    assign SELECTOR      = sel_q;
    assign share_cen     = share_q.cen;
    assign share_wen     = share_q.wen;
    assign share_ren     = share_q.ren;
    assign share_addr    = share_addr_q;
    assign weight_cen    = weight_q.cen;
    assign weight_wen    = weight_q.wen;
    assign weight_ren    = weight_q.ren;
    assign weight_addr   = weight_addr_q;
    assign activate_cen  = act_q.cen;
    assign activate_wen  = act_q.wen;
    assign activate_ren  = act_q.ren;
    assign activate_addr = act_addr_q;
    assign output_cen    = out_q.cen;
    assign output_wen    = out_q.wen;
    assign output_ren    = out_q.ren;
    assign output_addr   = out_addr_q;

endmodule

// File: tb/tb_mem_xfer_sequencer.sv
// Directed bench for mem_xfer_sequencer: per-cycle expected rows for the
// reference run, plus reuse, skip, wrap, freeze, abort and START-filter scenarios.
module tb_mem_xfer_sequencer;

    logic        CLK = 1'b0;
    logic        RESET, EN, START, REUSE_W;
    logic [12:0] WADDR, IADDR, OADDR;
    logic [7:0]  W_LEN, I_LEN, O_LEN, CALC_LEN;
    logic [2:0]  STATE;
    logic        BUSY, DONE, W_EN, SELECTOR;
    logic        share_cen, share_wen, share_ren;
    logic        weight_cen, weight_wen, weight_ren;
    logic        activate_cen, activate_wen, activate_ren;
    logic        output_cen, output_wen, output_ren;
    logic [12:0] share_addr, weight_addr, activate_addr, output_addr;

    int checks   = 0;
    int failures = 0;

    // memory control codes {cen,wen,ren}
    localparam logic [2:0] M_I = 3'b110;
    localparam logic [2:0] M_R = 3'b011;
    localparam logic [2:0] M_W = 3'b000;

    typedef struct packed {
        logic [2:0]  st;
        logic        busy;
        logic        done;
        logic        w_en;
        logic        sel;
        logic [2:0]  s_ctl;
        logic [12:0] s_addr;
        logic [2:0]  w_ctl;
        logic [12:0] w_addr;
        logic [2:0]  a_ctl;
        logic [12:0] a_addr;
        logic [2:0]  o_ctl;
        logic [12:0] o_addr;
    } row_t;

    localparam row_t RESET_ROW = {3'd0, 4'b0000, M_I, 13'h000, M_I, 13'h000, M_I, 13'h000, M_I, 13'h000};

    row_t tbl [1:18];

    mem_xfer_sequencer dut (
        .CLK(CLK), .RESET(RESET), .EN(EN), .START(START), .REUSE_W(REUSE_W),
        .WADDR(WADDR), .IADDR(IADDR), .OADDR(OADDR),
        .W_LEN(W_LEN), .I_LEN(I_LEN), .O_LEN(O_LEN), .CALC_LEN(CALC_LEN),
        .STATE(STATE), .BUSY(BUSY), .DONE(DONE), .W_EN(W_EN), .SELECTOR(SELECTOR),
        .share_cen(share_cen), .share_wen(share_wen), .share_ren(share_ren), .share_addr(share_addr),
        .weight_cen(weight_cen), .weight_wen(weight_wen), .weight_ren(weight_ren), .weight_addr(weight_addr),
        .activate_cen(activate_cen), .activate_wen(activate_wen), .activate_ren(activate_ren),
        .activate_addr(activate_addr),
        .output_cen(output_cen), .output_wen(output_wen), .output_ren(output_ren), .output_addr(output_addr)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

    function automatic row_t observe();
        return {STATE, BUSY, DONE, W_EN, SELECTOR,
                share_cen, share_wen, share_ren, share_addr,
                weight_cen, weight_wen, weight_ren, weight_addr,
                activate_cen, activate_wen, activate_ren, activate_addr,
                output_cen, output_wen, output_ren, output_addr};
    endfunction

    // Reference run: W 0x100/4, I 0x200/4, CALC 3, O 0x300/2; row c = after c-th edge from START.
    task automatic load_table();
        tbl[1]  = {3'd1, 4'b1000, M_R, 13'h100, M_I, 13'h000, M_I, 13'h000, M_I, 13'h000};
        tbl[2]  = {3'd1, 4'b1000, M_R, 13'h101, M_W, 13'h000, M_I, 13'h000, M_I, 13'h000};
        tbl[3]  = {3'd1, 4'b1000, M_R, 13'h102, M_W, 13'h001, M_I, 13'h000, M_I, 13'h000};
        tbl[4]  = {3'd1, 4'b1000, M_R, 13'h103, M_W, 13'h002, M_I, 13'h000, M_I, 13'h000};
        tbl[5]  = {3'd1, 4'b1000, M_I, 13'h103, M_W, 13'h003, M_I, 13'h000, M_I, 13'h000};
        tbl[6]  = {3'd2, 4'b1001, M_R, 13'h200, M_I, 13'h003, M_I, 13'h000, M_I, 13'h000};
        tbl[7]  = {3'd2, 4'b1001, M_R, 13'h201, M_I, 13'h003, M_W, 13'h000, M_I, 13'h000};
        tbl[8]  = {3'd2, 4'b1001, M_R, 13'h202, M_I, 13'h003, M_W, 13'h001, M_I, 13'h000};
        tbl[9]  = {3'd2, 4'b1001, M_R, 13'h203, M_I, 13'h003, M_W, 13'h002, M_I, 13'h000};
        tbl[10] = {3'd2, 4'b1001, M_I, 13'h203, M_I, 13'h003, M_W, 13'h003, M_I, 13'h000};
        tbl[11] = {3'd3, 4'b1010, M_I, 13'h203, M_I, 13'h003, M_I, 13'h003, M_I, 13'h000};
        tbl[12] = {3'd3, 4'b1000, M_I, 13'h203, M_I, 13'h003, M_I, 13'h003, M_I, 13'h000};
        tbl[13] = {3'd3, 4'b1000, M_I, 13'h203, M_I, 13'h003, M_I, 13'h003, M_I, 13'h000};
        tbl[14] = {3'd4, 4'b1000, M_I, 13'h203, M_I, 13'h003, M_I, 13'h003, M_R, 13'h000};
        tbl[15] = {3'd4, 4'b1000, M_W, 13'h300, M_I, 13'h003, M_I, 13'h003, M_R, 13'h001};
        tbl[16] = {3'd4, 4'b1000, M_W, 13'h301, M_I, 13'h003, M_I, 13'h003, M_I, 13'h001};
        tbl[17] = {3'd5, 4'b1100, M_I, 13'h301, M_I, 13'h003, M_I, 13'h003, M_I, 13'h001};
        tbl[18] = {3'd0, 4'b0000, M_I, 13'h301, M_I, 13'h003, M_I, 13'h003, M_I, 13'h001};
    endtask

    task automatic do_reset();
        RESET = 1'b1; EN = 1'b1; START = 1'b0; REUSE_W = 1'b0;
        WADDR = '0; IADDR = '0; OADDR = '0;
        W_LEN = '0; I_LEN = '0; O_LEN = '0; CALC_LEN = '0;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
    endtask

    task automatic set_basic();
        WADDR = 13'h100; W_LEN = 8'd4;
        IADDR = 13'h200; I_LEN = 8'd4;
        OADDR = 13'h300; O_LEN = 8'd2;
        CALC_LEN = 8'd3; REUSE_W = 1'b0;
    endtask

    // Returns at the sample point of cycle 1 (after the accepting edge).
    task automatic pulse_start();
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
    endtask

    task automatic test_reset();
        row_t r;
        do_reset();
        r = observe();
        checks++;
        if (r !== RESET_ROW) begin
            failures++;
            $display("FAIL reset_state got=%p want=%p", r, RESET_ROW);
        end
        repeat (3) @(negedge CLK);
        r = observe();
        checks++;
        if (r !== RESET_ROW) begin
            failures++;
            $display("FAIL reset_idle_hold got=%p want=%p", r, RESET_ROW);
        end
    endtask

    task automatic test_basic();
        row_t r;
        do_reset();
        set_basic();
        pulse_start();
        for (int c = 1; c <= 18; c++) begin
            r = observe();
            checks++;
            if (r !== tbl[c]) begin
                failures++;
                $display("FAIL basic_cycle%0d got=%p want=%p", c, r, tbl[c]);
            end
            if (c == 1) begin
                WADDR = 13'h0AA; IADDR = 13'h0BB; OADDR = 13'h0CC;
                W_LEN = 8'd9; I_LEN = 8'd1; O_LEN = 8'd7; CALC_LEN = 8'd20;
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_reuse();
        int done_at = -1;
        int w_hits  = 0;
        do_reset();
        set_basic();
        REUSE_W = 1'b1;
        pulse_start();
        REUSE_W = 1'b0;
        checks++;
        if (STATE !== 3'd2 || share_addr !== 13'h200 || share_cen !== 1'b0) begin
            failures++;
            $display("FAIL reuse_first_cycle got state=%0d addr=%h cen=%b want state=2 addr=200 cen=0",
                     STATE, share_addr, share_cen);
        end
        for (int c = 1; c <= 30; c++) begin
            if (weight_cen === 1'b0) w_hits++;
            if (DONE === 1'b1 && done_at < 0) done_at = c;
            @(negedge CLK);
        end
        checks++;
        if (done_at !== 12) begin
            failures++;
            $display("FAIL reuse_done_cycle got=%0d want=12", done_at);
        end
        checks++;
        if (w_hits !== 0) begin
            failures++;
            $display("FAIL reuse_no_weight_write got=%0d want=0", w_hits);
        end
    endtask

    task automatic test_skip();
        int done_at = -1;
        int hits    = 0;
        logic [2:0] st6 = 3'd7;
        do_reset();
        set_basic();
        I_LEN = 8'd0; O_LEN = 8'd0;
        pulse_start();
        for (int c = 1; c <= 12; c++) begin
            if (c == 6) st6 = STATE;
            if (activate_cen === 1'b0 || output_cen === 1'b0) hits++;
            if (DONE === 1'b1 && done_at < 0) done_at = c;
            @(negedge CLK);
        end
        checks++;
        if (st6 !== 3'd3) begin
            failures++;
            $display("FAIL skip_calc_after_loadw got=%0d want=3", st6);
        end
        checks++;
        if (done_at !== 9) begin
            failures++;
            $display("FAIL skip_done_cycle got=%0d want=9", done_at);
        end
        checks++;
        if (hits !== 0) begin
            failures++;
            $display("FAIL skip_no_act_out_access got=%0d want=0", hits);
        end
        checks++;
        if (STATE !== 3'd0 || BUSY !== 1'b0) begin
            failures++;
            $display("FAIL skip_back_idle got state=%0d busy=%b want 0/0", STATE, BUSY);
        end
    endtask

    task automatic test_wrap();
        logic [12:0] exp_addr [1:4];
        int done_at = -1;
        int wen_hits = 0;
        exp_addr[1] = 13'h1FFE; exp_addr[2] = 13'h1FFF;
        exp_addr[3] = 13'h0000; exp_addr[4] = 13'h0001;
        do_reset();
        set_basic();
        WADDR = 13'h1FFE; I_LEN = 8'd0; O_LEN = 8'd0; CALC_LEN = 8'd0;
        pulse_start();
        for (int c = 1; c <= 10; c++) begin
            if (c <= 4) begin
                checks++;
                if (share_addr !== exp_addr[c] || share_cen !== 1'b0) begin
                    failures++;
                    $display("FAIL wrap_addr_c%0d got=%h cen=%b want=%h cen=0", c, share_addr, share_cen, exp_addr[c]);
                end
            end
            if (W_EN === 1'b1) wen_hits++;
            if (DONE === 1'b1 && done_at < 0) done_at = c;
            @(negedge CLK);
        end
        checks++;
        if (done_at !== 7) begin
            failures++;
            $display("FAIL wrap_calc0_done_cycle got=%0d want=7", done_at);
        end
        checks++;
        if (wen_hits !== 1) begin
            failures++;
            $display("FAIL wrap_w_en_pulses got=%0d want=1", wen_hits);
        end
    endtask

    task automatic test_freeze();
        row_t r;
        int   k;
        do_reset();
        set_basic();
        pulse_start();
        for (int c = 1; c <= 21; c++) begin
            k = (c <= 7) ? c : ((c <= 10) ? 7 : c - 3);
            r = observe();
            checks++;
            if (r !== tbl[k]) begin
                failures++;
                $display("FAIL freeze_cycle%0d got=%p want=%p", c, r, tbl[k]);
            end
            if (c == 7)  EN = 1'b0;
            if (c == 10) EN = 1'b1;
            @(negedge CLK);
        end
    endtask

    task automatic test_start_busy();
        row_t r;
        do_reset();
        set_basic();
        pulse_start();
        for (int c = 1; c <= 18; c++) begin
            r = observe();
            checks++;
            if (r !== tbl[c]) begin
                failures++;
                $display("FAIL start_busy_cycle%0d got=%p want=%p", c, r, tbl[c]);
            end
            if (c == 3 || c == 12) begin
                START = 1'b1; REUSE_W = 1'b1; W_LEN = 8'd1; WADDR = 13'h055;
            end else begin
                START = 1'b0;
            end
            @(negedge CLK);
        end
        START = 1'b0;
    endtask

    task automatic test_start_en0();
        row_t r;
        do_reset();
        set_basic();
        EN = 1'b0;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        EN = 1'b1;
        @(negedge CLK);
        r = observe();
        checks++;
        if (r !== RESET_ROW) begin
            failures++;
            $display("FAIL start_with_en0_ignored got=%p want=%p", r, RESET_ROW);
        end
    endtask

    task automatic test_reset_abort();
        row_t r;
        int   dones = 0;
        do_reset();
        set_basic();
        pulse_start();
        repeat (14) @(negedge CLK);
        r = observe();
        checks++;
        if (r !== tbl[15]) begin
            failures++;
            $display("FAIL abort_pre_store got=%p want=%p", r, tbl[15]);
        end
        RESET = 1'b1;
        EN    = 1'b0;
        @(negedge CLK);
        r = observe();
        checks++;
        if (r !== RESET_ROW) begin
            failures++;
            $display("FAIL abort_reset_values got=%p want=%p", r, RESET_ROW);
        end
        RESET = 1'b0;
        EN    = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge CLK);
            if (DONE !== 1'b0 || STATE !== 3'd0) dones++;
        end
        checks++;
        if (dones !== 0) begin
            failures++;
            $display("FAIL abort_no_done got=%0d want=0", dones);
        end
    endtask

    initial begin
        load_table();
        test_reset();
        test_basic();
        test_reuse();
        test_skip();
        test_wrap();
        test_freeze();
        test_start_busy();
        test_start_en0();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
